hscl_phase_gen: RTL



---
 rtl/hscl_phase_gen_if.sv | 54 +++++
 rtl/hscl_phase_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hscl_phase_gen_if.sv
// hscl_phase_gen_if
//   This interface groups the line-control, configuration and output handshake signals of the
//   horizontal scaler phase generator.
//
//   The master modport is the phase generator itself.
//   The slave modport is the line controller or the downstream scaler.
//
//   Signals:
//     line_start     One-cycle pulse. Latches the config and starts (or restarts) a line.
//     cfg_step       Unsigned 2.8 input step per output pixel. 0 is treated as 0x100.
//     cfg_init       Initial fractional phase.
//     cfg_in_width   Input pixels per line (4..4095).
//     cfg_out_width  Output pixels per line (1..4095).
//     out_rdy        Downstream accepts the current output.
//     out_vld        Output valid.
//     out_idx        Source pixel index (centre tap).
//     out_ph         Filter phase.
//     en_ff0..3      Edge-replication flags.
//     out_last       Last pixel of the line. Qualified by out_vld.
//     line_done      One-cycle pulse after the last handshake of a line.
//     busy           High while a line is in progress.
interface hscl_phase_gen_if #(
    parameter int unsigned IDX_W  = 12,
    parameter int unsigned FRAC_W = 8
);
    logic              line_start;
    logic [9:0]        cfg_step;
    logic [FRAC_W-1:0] cfg_init;
    logic [IDX_W-1:0]  cfg_in_width;
    logic [IDX_W-1:0]  cfg_out_width;
    logic              out_rdy;
    logic              out_vld;
    logic [IDX_W-1:0]  out_idx;
    logic [1:0]        out_ph;
    logic              en_ff0;
    logic              en_ff1;
    logic              en_ff2;
    logic              en_ff3;
    logic              out_last;
    logic              line_done;
    logic              busy;

    modport master (
        input  line_start, cfg_step, cfg_init, cfg_in_width, cfg_out_width, out_rdy,
        output out_vld, out_idx, out_ph, en_ff0, en_ff1, en_ff2, en_ff3, out_last,
               line_done, busy
    );

    modport slave (
        output line_start, cfg_step, cfg_init, cfg_in_width, cfg_out_width, out_rdy,
        input  out_vld, out_idx, out_ph, en_ff0, en_ff1, en_ff2, en_ff3, out_last,
               line_done, busy
    );
endinterface

// File: rtl/hscl_phase_gen.sv
// hscl_phase_gen
//   This is the horizontal scaler phase generator. A DDA accumulator walks one line per
//   line_start. For each output pixel it emits the following values:
//     - the clamped source index
//     - the 2-bit filter phase
//     - the four edge-replication flags used by the 4-tap scaler
//   The output is a registered valid/ready stage.
//
//   Ports:
//     clk_scl    Clock.
//     rst_n_scl  Asynchronous, active-low reset.
//     bus        hscl_phase_gen_if.master. It carries the config, line control and the output
//                handshake.
//
//   Build option:
//     HSCL_PHASE_ROUND_EN  When defined, the loaded index and phase come from acc + half a phase
//                          step (rounding) instead of the truncated acc.
module hscl_phase_gen #(
    parameter int unsigned IDX_W  = 12,
    parameter int unsigned FRAC_W = 8
) (
    input  logic              clk_scl,
    input  logic              rst_n_scl,
    hscl_phase_gen_if.master  bus
);

    localparam int unsigned INT_W  = 14;
    localparam int unsigned ACC_W  = INT_W + FRAC_W;
    localparam int unsigned STEP_W = 10;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [IDX_W-1:0]   in_w_q, in_w_d;
    logic [IDX_W-1:0]   out_w_q, out_w_d;

    logic               vld_q, vld_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         ph_q, ph_d;
    logic [3:0]         flags_q, flags_d;   // {en_ff3, en_ff2, en_ff1, en_ff0}
    logic               last_q, last_d;
    logic               done_q, done_d;

    logic               hs;
    logic               load;
    logic [ACC_W-1:0]   pos;
    logic [INT_W-1:0]   pos_int;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   ld_idx;
    logic [3:0]         ld_flags;

    // Sampling position for the pixel being loaded. The accumulator itself never sees the
    // rounding offset.
`ifdef HSCL_PHASE_ROUND_EN
    localparam logic [ACC_W-1:0] RND = ACC_W'(2 ** (FRAC_W - 3));
    assign pos = acc_q + RND;
`else
    assign pos = acc_q;
`endif

    assign pos_int  = pos[ACC_W-1:FRAC_W];
    assign last_idx = in_w_q - IDX_W'(1);

    // Upscale can run the integer part past the last input pixel. Hold it at the edge.
    assign ld_idx = (pos_int > INT_W'(last_idx)) ? last_idx : pos_int[IDX_W-1:0];

    always_comb begin
        ld_flags = 4'b0000;
        if (ld_idx == '0) begin
            ld_flags = 4'b0010;
        end else if (ld_idx == in_w_q - IDX_W'(2)) begin
            ld_flags = 4'b1101;
        end else if (ld_idx == last_idx) begin
            ld_flags = 4'b0111;
        end
    end

    assign hs   = vld_q && bus.out_rdy;
    assign load = (state_q == StRun) && (!vld_q || bus.out_rdy) && (cnt_q < out_w_q);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        in_w_d  = in_w_q;
        out_w_d = out_w_q;
        vld_d   = vld_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        flags_d = flags_q;
        last_d  = last_q;
        done_d  = 1'b0;

        if (bus.line_start) begin
            // Restart wins over everything. This includes a coincident last handshake, so no
            // line_done is produced for the aborted line.
            state_d = StRun;
            step_d  = (bus.cfg_step == '0) ? STEP_W'(10'h100) : bus.cfg_step;
            in_w_d  = bus.cfg_in_width;
            out_w_d = bus.cfg_out_width;
            acc_d   = {{INT_W{1'b0}}, bus.cfg_init};
            cnt_d   = '0;
            vld_d   = 1'b0;
            last_d  = 1'b0;
        end else if (state_q == StRun) begin
            if (load) begin
                vld_d   = 1'b1;
                idx_d   = ld_idx;
                ph_d    = pos[FRAC_W-1:FRAC_W-2];
                flags_d = ld_flags;
                last_d  = (cnt_q == out_w_q - IDX_W'(1));
                acc_d   = acc_q + {{(ACC_W-STEP_W){1'b0}}, step_q};
                cnt_d   = cnt_q + IDX_W'(1);
            end else if (hs) begin
                vld_d = 1'b0;
            end
            if (hs && last_q) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            step_q  <= '0;
            in_w_q  <= '0;
            out_w_q <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            ph_q    <= '0;
            flags_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            in_w_q  <= in_w_d;
            out_w_q <= out_w_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
            ph_q    <= ph_d;
            flags_q <= flags_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign bus.out_vld   = vld_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_ph    = ph_q;
    assign bus.en_ff0    = flags_q[0];
    assign bus.en_ff1    = flags_q[1];
    assign bus.en_ff2    = flags_q[2];
    assign bus.en_ff3    = flags_q[3];
    assign bus.out_last  = last_q;
    assign bus.line_done = done_q;
    assign bus.busy      = (state_q == StRun);

endmodule
